// File: rtl/exec_sequencer.sv
// exec_sequencer: run controller for the ternary system.
// Sequences the program loader and the CPU through load, execute and halt, owns the single
// shared memory write port, and decides when a run is finished (PC stalled in fetch) or has
// run away (execute-cycle watchdog).
//
// Ports:
//   clock, reset                  system clock, asynchronous active-high reset
//   start                         run request (IDLE or HALTED only)
//   ld_start                      one-cycle loader start pulse
//   ld_done, ld_mem_*             loader status and memory write request
//   cpu_clear, cpu_run            one-cycle CPU soft clear, CPU clock-enable
//   cpu_pc, cpu_state, cpu_mem_*  CPU status and memory write request
//   mem_write, mem_addr,
//   mem_write_data                shared memory write port (combinational mux)
//   system_state                  IDLE=0, LOADING=1, EXECUTING=2, HALTED=3
//   halted, timeout               run finished; finish caused by the watchdog
//   exec_cycles                   saturating count of cpu_run cycles
module exec_sequencer #(
    parameter logic [2:0]  FETCH_STATE = 3'd0,
    parameter int unsigned HALT_CYCLES = 5,
    parameter int unsigned MAX_CYCLES  = 1000,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    output logic             ld_start,
    input  logic             ld_done,
    input  logic             ld_mem_write,
    input  logic [17:0]      ld_mem_addr,
    input  logic [17:0]      ld_mem_write_data,
    output logic             cpu_clear,
    output logic             cpu_run,
    input  logic [17:0]      cpu_pc,
    input  logic [2:0]       cpu_state,
    input  logic             cpu_mem_write,
    input  logic [17:0]      cpu_mem_address,
    input  logic [17:0]      cpu_mem_write_data,
    output logic             mem_write,
    output logic [17:0]      mem_addr,
    output logic [17:0]      mem_write_data,
    output logic [1:0]       system_state,
    output logic             halted,
    output logic             timeout,
    output logic [CNT_W-1:0] exec_cycles
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LOADING   = 2'd1;
    localparam logic [1:0] EXECUTING = 2'd2;
    localparam logic [1:0] HALTED    = 2'd3;

    localparam int unsigned       STALL_W    = $clog2(HALT_CYCLES + 1);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(HALT_CYCLES - 1);
    localparam logic [CNT_W-1:0]   WDOG_LAST  = CNT_W'(MAX_CYCLES - 1);
    // All-ones is not a valid trit pattern, so the first fetch can never match it.
    localparam logic [17:0]        PC_INVALID = 18'h3FFFF;

    logic [1:0]         state_q, state_d;
    logic               ld_start_q, ld_start_d;
    logic               cpu_clear_q, cpu_clear_d;
    logic               cpu_run_q, cpu_run_d;
    logic               halted_q, halted_d;
    logic               timeout_q, timeout_d;
    logic [CNT_W-1:0]   exec_cycles_q, exec_cycles_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [17:0]        prev_pc_q, prev_pc_d;

    logic stall_match;
    logic stall_hit;
    logic wdog_hit;

    always_comb begin
        stall_match = cpu_run_q && (cpu_state == FETCH_STATE) && (cpu_pc == prev_pc_q);
        stall_hit   = stall_match && (stall_cnt_q == STALL_LAST);
        wdog_hit    = (MAX_CYCLES != 0) && cpu_run_q && (exec_cycles_q == WDOG_LAST);

        state_d       = state_q;
        ld_start_d    = 1'b0;
        cpu_clear_d   = 1'b0;
        cpu_run_d     = 1'b0;
        halted_d      = halted_q;
        timeout_d     = timeout_q;
        exec_cycles_d = exec_cycles_q;
        stall_cnt_d   = stall_cnt_q;
        prev_pc_d     = prev_pc_q;

        if (cpu_run_q) begin
            prev_pc_d   = cpu_pc;
            stall_cnt_d = stall_match ? stall_cnt_q + 1'b1 : '0;
            if (exec_cycles_q != '1) begin
                exec_cycles_d = exec_cycles_q + 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d    = LOADING;
                    ld_start_d = 1'b1;
                end
            end
            LOADING: begin
                if (ld_done) begin
                    state_d     = EXECUTING;
                    cpu_clear_d = 1'b1;
                    prev_pc_d   = PC_INVALID;
                    stall_cnt_d = '0;
                end
            end
            EXECUTING: begin
                if (stall_hit || wdog_hit) begin
                    state_d   = HALTED;
                    halted_d  = 1'b1;
                    // A genuine completion wins over a coincident watchdog expiry.
                    timeout_d = wdog_hit && !stall_hit;
                end else begin
                    cpu_run_d = 1'b1;
                end
            end
            HALTED: begin
                if (start) begin
                    state_d       = LOADING;
                    ld_start_d    = 1'b1;
                    halted_d      = 1'b0;
                    timeout_d     = 1'b0;
                    exec_cycles_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ld_start_q    <= 1'b0;
            cpu_clear_q   <= 1'b0;
            cpu_run_q     <= 1'b0;
            halted_q      <= 1'b0;
            timeout_q     <= 1'b0;
            exec_cycles_q <= '0;
            stall_cnt_q   <= '0;
            prev_pc_q     <= PC_INVALID;
        end else begin
            state_q       <= state_d;
            ld_start_q    <= ld_start_d;
            cpu_clear_q   <= cpu_clear_d;
            cpu_run_q     <= cpu_run_d;
            halted_q      <= halted_d;
            timeout_q     <= timeout_d;
            exec_cycles_q <= exec_cycles_d;
            stall_cnt_q   <= stall_cnt_d;
            prev_pc_q     <= prev_pc_d;
        end
    end

    // Memory port: zero-latency ownership mux; writes from the non-owner never get through.
    always_comb begin
        mem_write      = 1'b0;
        mem_addr       = '0;
        mem_write_data = '0;
        case (state_q)
            LOADING: begin
                mem_write      = ld_mem_write;
                mem_addr       = ld_mem_addr;
                mem_write_data = ld_mem_write_data;
            end
            EXECUTING: begin
                mem_write      = cpu_mem_write;
                mem_addr       = cpu_mem_address;
                mem_write_data = cpu_mem_write_data;
            end
            HALTED: begin
                mem_addr       = cpu_mem_address;
                mem_write_data = cpu_mem_write_data;
            end
            default: ;
        endcase
    end

    assign system_state = state_q;
    assign ld_start     = ld_start_q;
    assign cpu_clear    = cpu_clear_q;
    assign cpu_run      = cpu_run_q;
    assign halted       = halted_q;
    assign timeout      = timeout_q;
    assign exec_cycles  = exec_cycles_q;

endmodule
